// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter/sequencer for the single-port data memory.
//   Port C (core load/store) and port L (loader/debug) share one
//   fixed-latency synchronous memory. One request is in flight at a time.
//   Each request passes through IDLE -> ISSUE -> WAIT -> RESP and finishes
//   with a single-cycle resp_valid pulse to the owner.
//
//   Configuration macro: DMEM_ARB_RR_EN
//     defined   : ties go round-robin. The port not served last wins, and
//                 the first tie after reset goes to C.
//     undefined : fixed priority, so C wins every tie.
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     c_/l_valid, c_/l_ready        request handshake (ready only in IDLE)
//     c_/l_we, _addr, _wdata        request payload
//     c_/l_resp_valid, c_/l_rdata   completion pulse and load data
//                                   (rdata is 0 for stores and holds
//                                   between responses)
//     mem_en/we/addr/wdata/rdata    memory interface; rdata is valid
//                                   MEM_LATENCY cycles after mem_en
//     busy                          high in any state other than IDLE
//     grant_id                      owner of current/last access (0=C, 1=L)
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_resp_valid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  l_valid,
    output logic                  l_ready,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    output logic                  l_resp_valid,
    output logic [DATA_WIDTH-1:0] l_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       we_q;
    logic       grant_l;   // winner when at least one port is valid: 1 = L
    logic       accept;

    // ---------------- arbitration ----------------
`ifdef DMEM_ARB_RR_EN
    logic last_l;          // 1 = L was served by the previous transaction

    always_comb begin
        if (c_valid && l_valid)
            grant_l = ~last_l;
        else
            grant_l = ~c_valid;
    end
`else
    always_comb begin
        grant_l = ~c_valid;
    end
`endif

    assign accept = (state == ST_IDLE) && (c_valid || l_valid);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (c_valid || l_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == 4'd0) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        c_ready      = 1'b0;
        l_ready      = 1'b0;
        mem_en       = 1'b0;
        c_resp_valid = 1'b0;
        l_resp_valid = 1'b0;
        busy         = (state != ST_IDLE);
        // The latched we survives into IDLE, so gate it with busy to keep mem_we low there.
        mem_we       = (state != ST_IDLE) && we_q;
        unique case (state)
            ST_IDLE: begin
                c_ready = c_valid && !grant_l;
                l_ready = l_valid &&  grant_l;
            end
            ST_ISSUE: mem_en = 1'b1;
            ST_RESP: begin
                c_resp_valid = !grant_id;
                l_resp_valid =  grant_id;
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant_id  <= 1'b0;
            c_rdata   <= '0;
            l_rdata   <= '0;
`ifdef DMEM_ARB_RR_EN
            last_l    <= 1'b1;
`endif
        end else begin
            if (accept) begin
                we_q      <= grant_l ? l_we    : c_we;
                mem_addr  <= grant_l ? l_addr  : c_addr;
                mem_wdata <= grant_l ? l_wdata : c_wdata;
                grant_id  <= grant_l;
`ifdef DMEM_ARB_RR_EN
                last_l    <= grant_l;
`endif
            end
            if (state == ST_ISSUE)
                cnt <= LAT_M1;
            if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
                // Capture in the cycle mem_rdata is valid. This keeps mem_rdata off any combinational output path.
                if (cnt == 4'd0) begin
                    if (grant_id)
                        l_rdata <= we_q ? '0 : mem_rdata;
                    else
                        c_rdata <= we_q ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;

    logic        c_valid = 1'b0, l_valid = 1'b0;
    logic        c_valid4 = 1'b0, l_valid4 = 1'b0;
    logic        c_we = 1'b0, l_we = 1'b0;
    logic [31:0] c_addr = '0, l_addr = '0, c_wdata = '0, l_wdata = '0;

    // MEM_LATENCY = 1 instance
    logic        c_ready, l_ready, c_resp_valid, l_resp_valid;
    logic [31:0] c_rdata, l_rdata;
    logic        mem_en, mem_we, busy, grant_id;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // MEM_LATENCY = 4 instance
    logic        c_ready4, l_ready4, c_resp_valid4, l_resp_valid4;
    logic [31:0] c_rdata4, l_rdata4;
    logic        mem_en4, mem_we4, busy4, grant_id4;
    logic [31:0] mem_addr4, mem_wdata4, mem_rdata4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_resp_valid(c_resp_valid), .c_rdata(c_rdata),
        .l_valid(l_valid), .l_ready(l_ready), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_resp_valid(l_resp_valid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .c_valid(c_valid4), .c_ready(c_ready4), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_resp_valid(c_resp_valid4), .c_rdata(c_rdata4),
        .l_valid(l_valid4), .l_ready(l_ready4), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_resp_valid(l_resp_valid4), .l_rdata(l_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4), .busy(busy4), .grant_id(grant_id4)
    );

    // Memory models: word array indexed by addr[9:2]. Read data is present only
    // in the cycle exactly MEM_LATENCY after mem_en. At all other times it is a marker value.
    logic [31:0] mem [0:255];
    logic [31:0] p1;
    logic [31:0] p4 [0:3];
    assign mem_rdata  = p1;
    assign mem_rdata4 = p4[3];

    always @(posedge clk) begin
        if (load_en) begin
            mem[8'd64] <= 32'hDEADBEEF;   // 0x100
            mem[8'd16] <= 32'h00000040;   // 0x40
        end
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            p1 <= mem_we ? 32'hBADBAD00 : mem[mem_addr[9:2]];
        end else begin
            p1 <= 32'hBADBAD00;
        end
        p4[0] <= (mem_en4 && !mem_we4) ? mem[mem_addr4[9:2]] : 32'hBADBAD04;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one request on a port of the latency-1 instance and wait for its
    // response. lat is the number of cycles from acceptance to resp_valid.
    task automatic transact(input bit port, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output int lat);
        int n;
        @(posedge clk); #1;
        if (port) begin l_valid = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata; end
        else      begin c_valid = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; end
        n = 0;
        @(negedge clk);
        while (!(port ? l_ready : c_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL accept_timeout: port=%0d not accepted within %0d cycles", port, n);
        end
        @(posedge clk); #1;
        c_valid = 1'b0;
        l_valid = 1'b0;
        lat = 0;
        rdata = 'x;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (port ? l_resp_valid : c_resp_valid) begin
                rdata = port ? l_rdata : c_rdata;
                break;
            end
        end
        checks++;
        if (lat >= 20) begin
            errors++;
            $display("FAIL resp_timeout: port=%0d no response within %0d cycles", port, lat);
        end
    endtask

    task automatic test_reset();
        load_en = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({c_ready, l_ready, c_resp_valid, l_resp_valid, mem_en, mem_we, busy, grant_id} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {c_ready, l_ready, c_resp_valid, l_resp_valid, mem_en, mem_we, busy, grant_id});
        end
        checks++;
        if ({mem_addr, mem_wdata, c_rdata, l_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h c_rdata=%h l_rdata=%h expected all 0",
                     mem_addr, mem_wdata, c_rdata, l_rdata);
        end
        checks++;
        if ({busy4, mem_en4, c_rdata4} !== 34'h0) begin
            errors++;
            $display("FAIL reset_dut4: busy=%b mem_en=%b c_rdata=%h expected 0", busy4, mem_en4, c_rdata4);
        end
    endtask

    task automatic test_core_load();
        logic l_seen;
        l_seen = 1'b0;
        @(posedge clk); #1;
        c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h100; c_wdata = '0;
        @(negedge clk);                                     // T
        checks++;
        if (c_ready !== 1'b1 || l_ready !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL load_T: c_ready=%b l_ready=%b mem_en=%b expected 1 0 0", c_ready, l_ready, mem_en);
        end
        l_seen |= l_resp_valid;
        @(posedge clk); #1 c_valid = 1'b0;
        @(negedge clk);                                     // T+1
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || grant_id !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_T1: en=%b addr=%h we=%b gid=%b busy=%b expected 1 00000100 0 0 1",
                     mem_en, mem_addr, mem_we, grant_id, busy);
        end
        l_seen |= l_resp_valid;
        @(negedge clk);                                     // T+2
        checks++;
        if (c_resp_valid !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL load_T2: resp=%b mem_en=%b expected 0 0", c_resp_valid, mem_en);
        end
        l_seen |= l_resp_valid;
        @(negedge clk);                                     // T+3
        checks++;
        if (c_resp_valid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_T3: resp=%b rdata=%h expected 1 deadbeef", c_resp_valid, c_rdata);
        end
        l_seen |= l_resp_valid;
        checks++;
        if (l_seen !== 1'b0) begin
            errors++;
            $display("FAIL load_l_resp: l_resp_valid got %b expected 0", l_seen);
        end
        @(negedge clk);                                     // T+4
        checks++;
        if (c_resp_valid !== 1'b0 || busy !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_T4: resp=%b busy=%b rdata=%h expected 0 0 deadbeef", c_resp_valid, busy, c_rdata);
        end
    endtask

    task automatic test_loader_store_load();
        logic [31:0] rd;
        int lat;
        @(posedge clk); #1;
        l_valid = 1'b1; l_we = 1'b1; l_addr = 32'h40; l_wdata = 32'h12345678;
        @(negedge clk);                                     // T
        checks++;
        if (l_ready !== 1'b1 || c_ready !== 1'b0) begin
            errors++;
            $display("FAIL store_T: l_ready=%b c_ready=%b expected 1 0", l_ready, c_ready);
        end
        @(posedge clk); #1 l_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678 || mem_en !== (i == 1)) begin
                errors++;
                $display("FAIL store_hold: T+%0d we=%b addr=%h wdata=%h en=%b expected 1 00000040 12345678 %0d",
                         i, mem_we, mem_addr, mem_wdata, mem_en, (i == 1));
            end
        end
        checks++;
        if (l_resp_valid !== 1'b1 || l_rdata !== 32'h0 || c_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_resp: l_resp=%b l_rdata=%h c_resp=%b expected 1 00000000 0",
                     l_resp_valid, l_rdata, c_resp_valid);
        end
        @(negedge clk);                                     // T+4, IDLE
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL store_idle_we: mem_we=%b busy=%b expected 0 0", mem_we, busy);
        end
        transact(1'b1, 1'b0, 32'h40, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h12345678 || lat != 3) begin
            errors++;
            $display("FAIL load_back: rdata=%h lat=%0d expected 12345678 3", rd, lat);
        end
    endtask

    task automatic test_tie();
        logic [3:0] exp_g;
        int n;
        logic g;
`ifdef DMEM_ARB_RR_EN
        exp_g = 4'b1010;   // bit k = grant of transaction k (1 = L): C,L,C,L
`else
        exp_g = 4'b0000;   // C,C,C,C
`endif
        apply_reset();
        c_we = 1'b0; c_addr = 32'h100;
        l_we = 1'b0; l_addr = 32'h40;
        c_valid = 1'b1; l_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (!(c_ready || l_ready) && n < 20) begin
                @(negedge clk);
                n++;
            end
            g = l_ready;
            checks++;
            if ((c_ready ^ l_ready) !== 1'b1 || g !== exp_g[k]) begin
                errors++;
                $display("FAIL tie_grant%0d: c_ready=%b l_ready=%b expected l_ready=%b alone",
                         k, c_ready, l_ready, exp_g[k]);
            end
            if (k > 0) begin
                checks++;
                if (n != 3) begin
                    errors++;
                    $display("FAIL tie_spacing%0d: waited %0d expected 3", k, n);
                end
            end
            @(posedge clk); #1;
        end
        c_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!l_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL tie_l_after_c_drop: waited %0d expected 3", n);
        end
        @(posedge clk); #1 l_valid = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_latency4();
        apply_reset();
        c_we = 1'b0; c_addr = 32'h100; l_we = 1'b0; l_addr = 32'h40;
        c_valid4 = 1'b1; l_valid4 = 1'b1;
        @(negedge clk);                                     // T
        checks++;
        if (c_ready4 !== 1'b1 || l_ready4 !== 1'b0) begin
            errors++;
            $display("FAIL lat4_T: c_ready=%b l_ready=%b expected 1 0", c_ready4, l_ready4);
        end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (busy4 !== 1'b1 || c_ready4 !== 1'b0 || l_ready4 !== 1'b0 ||
                c_resp_valid4 !== (i == 6) || l_resp_valid4 !== 1'b0 || mem_en4 !== (i == 1)) begin
                errors++;
                $display("FAIL lat4_T%0d: busy=%b rdy=%b%b resp=%b%b en=%b expected 1 00 %0d0 %0d",
                         i, busy4, c_ready4, l_ready4, c_resp_valid4, l_resp_valid4, mem_en4,
                         (i == 6), (i == 1));
            end
        end
        checks++;
        if (c_rdata4 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lat4_rdata: got %h expected deadbeef", c_rdata4);
        end
        @(posedge clk); #1;
        c_valid4 = 1'b0; l_valid4 = 1'b0;
        @(negedge clk);                                     // T+7
        checks++;
        if (busy4 !== 1'b0 || c_resp_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL lat4_T7: busy=%b resp=%b expected 0 0", busy4, c_resp_valid4);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        logic seen;
        transact(1'b1, 1'b0, 32'h40, 32'h0, rd, lat);       // leaves l_rdata nonzero
        @(posedge clk); #1;
        c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h100;
        @(negedge clk);                                     // T
        checks++;
        if (c_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_accept: c_ready=%b expected 1", c_ready);
        end
        @(posedge clk); #1 c_valid = 1'b0;                  // T+1 ISSUE
        @(posedge clk); #1 rst = 1'b1;                      // T+2 WAIT
        @(negedge clk);
        @(negedge clk);                                     // T+3
        checks++;
        if ({c_ready, l_ready, c_resp_valid, l_resp_valid, mem_en, mem_we, busy, grant_id} !== 8'h00 ||
            {mem_addr, mem_wdata, c_rdata, l_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: ctrl=%b addr=%h wdata=%h c_rdata=%h l_rdata=%h expected all 0",
                     {c_ready, l_ready, c_resp_valid, l_resp_valid, mem_en, mem_we, busy, grant_id},
                     mem_addr, mem_wdata, c_rdata, l_rdata);
        end
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= c_resp_valid | l_resp_valid | busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_dropped: activity after reset got %b expected 0", seen);
        end
        transact(1'b1, 1'b0, 32'h40, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h12345678 || lat != 3) begin
            errors++;
            $display("FAIL rstmid_next: rdata=%h lat=%0d expected 12345678 3", rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_core_load();
        test_loader_store_load();
        test_tie();
        test_latency4();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
